// File: rtl/instr_encode_loader_pkg.sv
// Shared types for the instruction encode/loader: formats, FSM states, field widths.
// Also holds the MIPS opcode and function-code values used by the optional op check.
// Pure declarations, no logic; imported by the loader top and the field packer.
package instr_encode_loader_pkg;

  localparam int AddrW   = 10;
  localparam int WordW   = 32;
  localparam int CountW  = 11;
  localparam int OpW     = 6;
  localparam int FuncW   = 6;
  localparam int RegW    = 5;
  localparam int ShamtW  = 5;
  localparam int ImmW    = 16;
  localparam int TargetW = 26;

  localparam logic [AddrW-1:0] AddrMax = '1;

  typedef enum logic [1:0] {
    FmtR    = 2'd0,
    FmtI    = 2'd1,
    FmtJ    = 2'd2,
    FmtRsvd = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccept = 2'd1,
    StWrite  = 2'd2,
    StDone   = 2'd3
  } state_e;

  typedef struct packed {
    logic [OpW-1:0]     op;
    logic [FuncW-1:0]   func;
    logic [RegW-1:0]    rs;
    logic [RegW-1:0]    rt;
    logic [RegW-1:0]    rd;
    logic [ShamtW-1:0]  shamt;
    logic [ImmW-1:0]    imm;
    logic [TargetW-1:0] target;
  } req_t;

  // MIPS primary opcodes
  localparam logic [OpW-1:0] OpRegimm = 6'h01;  // BGEZ lives under REGIMM
  localparam logic [OpW-1:0] OpJ      = 6'h02;
  localparam logic [OpW-1:0] OpJal    = 6'h03;
  localparam logic [OpW-1:0] OpBeq    = 6'h04;
  localparam logic [OpW-1:0] OpBne    = 6'h05;
  localparam logic [OpW-1:0] OpBlez   = 6'h06;
  localparam logic [OpW-1:0] OpBgtz   = 6'h07;
  localparam logic [OpW-1:0] OpAddi   = 6'h08;
  localparam logic [OpW-1:0] OpAddiu  = 6'h09;
  localparam logic [OpW-1:0] OpSlti   = 6'h0A;
  localparam logic [OpW-1:0] OpSltiu  = 6'h0B;
  localparam logic [OpW-1:0] OpAndi   = 6'h0C;
  localparam logic [OpW-1:0] OpOri    = 6'h0D;
  localparam logic [OpW-1:0] OpXori   = 6'h0E;
  localparam logic [OpW-1:0] OpLui    = 6'h0F;
  localparam logic [OpW-1:0] OpLb     = 6'h20;
  localparam logic [OpW-1:0] OpLh     = 6'h21;
  localparam logic [OpW-1:0] OpLw     = 6'h23;
  localparam logic [OpW-1:0] OpLbu    = 6'h24;
  localparam logic [OpW-1:0] OpLhu    = 6'h25;
  localparam logic [OpW-1:0] OpSb     = 6'h28;
  localparam logic [OpW-1:0] OpSh     = 6'h29;
  localparam logic [OpW-1:0] OpSw     = 6'h2B;

  // MIPS SPECIAL function codes
  localparam logic [FuncW-1:0] FnSll  = 6'h00;
  localparam logic [FuncW-1:0] FnSrl  = 6'h02;
  localparam logic [FuncW-1:0] FnSra  = 6'h03;
  localparam logic [FuncW-1:0] FnSllv = 6'h04;
  localparam logic [FuncW-1:0] FnSrlv = 6'h06;
  localparam logic [FuncW-1:0] FnSrav = 6'h07;
  localparam logic [FuncW-1:0] FnJr   = 6'h08;
  localparam logic [FuncW-1:0] FnAdd  = 6'h20;
  localparam logic [FuncW-1:0] FnAddu = 6'h21;
  localparam logic [FuncW-1:0] FnSub  = 6'h22;
  localparam logic [FuncW-1:0] FnSubu = 6'h23;
  localparam logic [FuncW-1:0] FnAnd  = 6'h24;
  localparam logic [FuncW-1:0] FnOr   = 6'h25;
  localparam logic [FuncW-1:0] FnXor  = 6'h26;
  localparam logic [FuncW-1:0] FnSlt  = 6'h2A;
  localparam logic [FuncW-1:0] FnSltu = 6'h2B;

  function automatic logic isSupportedFunc(input logic [FuncW-1:0] func);
    case (func)
      FnSll, FnSrl, FnSra, FnSllv, FnSrlv, FnSrav, FnJr,
      FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor,
      FnSlt, FnSltu: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic isSupportedOp(input logic [OpW-1:0] op);
    case (op)
      OpAddi, OpAddiu, OpAndi, OpOri, OpXori, OpLui, OpSlti, OpSltiu,
      OpLw, OpLh, OpLhu, OpLb, OpLbu, OpSw, OpSh, OpSb,
      OpBeq, OpBne, OpRegimm, OpBgtz, OpBlez, OpJ, OpJal: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Packs request fields into a 32-bit MIPS word and flags unsupported requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is sampled.
module instr_field_packer
  import instr_encode_loader_pkg::*;
(
  input  fmt_e             fmt,
  input  req_t             fields,
  output logic [WordW-1:0] encWord,
  output logic             encValid
);

  // Format-dependent field concatenation; the reserved format encodes as zero.
  always_comb begin
    encWord = '0;
    case (fmt)
      FmtR:    encWord = {6'b0, fields.rs, fields.rt, fields.rd, fields.shamt, fields.func};
      FmtI:    encWord = {fields.op, fields.rs, fields.rt, fields.imm};
      FmtJ:    encWord = {fields.op, fields.target};
      default: encWord = '0;
    endcase
  end

`ifdef ENC_OPCHECK_EN
  // R-format is judged on func, I/J on the primary opcode; the reserved format never passes.
  always_comb begin
    encValid = 1'b0;
    case (fmt)
      FmtR:       encValid = isSupportedFunc(fields.func);
      FmtI, FmtJ: encValid = isSupportedOp(fields.op);
      default:    encValid = 1'b0;
    endcase
  end
`else
  assign encValid = 1'b1;
`endif

endmodule

// File: rtl/instr_encode_loader.sv
// Accepts encode requests and writes packed instructions into sequential imem words.
// Latency: write one cycle after accept; at most one word every two cycles.
// Backpressure: req_ready high only in ACCEPT. Optional ENC_OPCHECK_EN drops unsupported ops.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AddrW-1:0]   base_addr,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_fmt,
  input  logic               req_last,
  input  logic [OpW-1:0]     req_op,
  input  logic [FuncW-1:0]   req_func,
  input  logic [RegW-1:0]    req_rs,
  input  logic [RegW-1:0]    req_rt,
  input  logic [RegW-1:0]    req_rd,
  input  logic [ShamtW-1:0]  req_shamt,
  input  logic [ImmW-1:0]    req_imm,
  input  logic [TargetW-1:0] req_target,
  output logic               imem_we,
  output logic [AddrW-1:0]   imem_addr,
  output logic [WordW-1:0]   imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err_ovf,
  output logic               err_invop,
  output logic [CountW-1:0]  word_count
);

  state_e            state;
  state_e            stateNext;
  logic [AddrW-1:0]  addr;
  logic [CountW-1:0] wordCount;
  logic [WordW-1:0]  wordReg;
  logic              lastReg;
  logic              errOvf;
  logic [WordW-1:0]  encWord;
  logic              encValid;
  req_t              reqFields;

  assign reqFields = '{op: req_op, func: req_func, rs: req_rs, rt: req_rt, rd: req_rd,
                       shamt: req_shamt, imm: req_imm, target: req_target};

  instr_field_packer uPacker (
    .fmt      (fmt_e'(req_fmt)),
    .fields   (reqFields),
    .encWord  (encWord),
    .encValid (encValid)
  );

  // State register; async reset lands in IDLE so imem_we drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= StIdle;
    else     state <= stateNext;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    stateNext = state;
    req_ready = 1'b0;
    imem_we   = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      StIdle: begin
        busy = 1'b0;
        if (start) stateNext = StAccept;
      end
      StAccept: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (encValid)      stateNext = StWrite;
          else if (req_last) stateNext = StDone;
        end
      end
      StWrite: begin
        imem_we = 1'b1;
        // The top word is the last one we may touch, so the session ends there.
        if (lastReg || addr == AddrMax) stateNext = StDone;
        else                            stateNext = StAccept;
      end
      StDone: begin
        done      = 1'b1;
        stateNext = StIdle;
      end
      default: stateNext = StIdle;
    endcase
  end

  // Session datapath: address pointer, captured word, counters and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      wordCount <= '0;
      wordReg   <= '0;
      lastReg   <= 1'b0;
      errOvf    <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            addr      <= base_addr;
            wordCount <= '0;
            errOvf    <= 1'b0;
          end
        end
        StAccept: begin
          if (req_valid && encValid) begin
            wordReg <= encWord;
            lastReg <= req_last;
          end
        end
        StWrite: begin
          wordCount <= wordCount + 1'b1;
          // Pointer parks at the top word instead of wrapping to zero.
          if (addr == AddrMax) begin
            if (!lastReg) errOvf <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENC_OPCHECK_EN
  logic errInvop;

  // One-cycle flag for a request consumed without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) errInvop <= 1'b0;
    else     errInvop <= (state == StAccept) && req_valid && !encValid;
  end

  assign err_invop = errInvop;
`else
  assign err_invop = 1'b0;
`endif

  assign imem_addr  = addr;
  assign imem_wdata = wordReg;
  assign err_ovf    = errOvf;
  assign word_count = wordCount;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader with a write scoreboard.
// Expected writes are queued as requests are driven and popped when imem_we is seen.
// Build with ENC_OPCHECK_EN to exercise the unsupported-op path.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_fmt;
  logic        req_last;
  logic [5:0]  req_op;
  logic [5:0]  req_func;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [4:0]  req_shamt;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err_ovf;
  logic        err_invop;
  logic [10:0] word_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t expQ[$];

  always #5 clk = ~clk;

  instr_encode_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fmt    (req_fmt),
    .req_last   (req_last),
    .req_op     (req_op),
    .req_func   (req_func),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_shamt  (req_shamt),
    .req_imm    (req_imm),
    .req_target (req_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err_ovf    (err_ovf),
    .err_invop  (err_invop),
    .word_count (word_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      check("write_expected", expQ.size() > 0, 1);
      if (expQ.size() > 0) begin
        wr_t e;
        e = expQ.pop_front();
        check("write_addr", {22'b0, imem_addr}, {22'b0, e.a});
        check("write_data", imem_wdata, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic doStart(input logic [9:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("count_cleared", word_count, 0);
  endtask

  task automatic sendReq(input string tag, input logic [1:0] fmt, input logic [5:0] op,
                         input logic [5:0] func, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                         input logic last, input bit expWrite, input logic [9:0] expAddr,
                         input logic [31:0] expData, input bit hold, output int waits);
    req_fmt = fmt; req_op = op; req_func = func; req_rs = rs; req_rt = rt; req_rd = rd;
    req_shamt = 5'd0; req_imm = imm; req_target = tgt; req_last = last;
    req_valid = 1'b1;
    waits = 0;
    if (expWrite) expQ.push_back(wr_t'{expAddr, expData});
    while (req_ready !== 1'b1 && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    check({tag, "_ready"}, req_ready, 1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    check({tag, "_we_next_cycle"}, imem_we, expWrite);
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, done, 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse_end"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; base_addr = '0; req_valid = 1'b0;
    req_fmt = '0; req_last = 1'b0; req_op = '0; req_func = '0; req_rs = '0; req_rt = '0;
    req_rd = '0; req_shamt = '0; req_imm = '0; req_target = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", req_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", {22'b0, imem_addr}, 0);
    check("rst_count", word_count, 0);
    check("rst_ovf", err_ovf, 0);
    check("rst_invop", err_invop, 0);
    rst = 1'b0;

    // R-format ADDU, single last request
    doStart(10'h010);
    sendReq("addu", 2'd0, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1,
            1'b1, 10'h010, 32'h00221821, 1'b0, w);
    waitDone("addu");
    check("addu_count", word_count, 1);

    // Two I-format words, the second flagged last
    doStart(10'h000);
    sendReq("addi", 2'd1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 1'b0,
            1'b1, 10'h000, 32'h20080005, 1'b0, w);
    sendReq("lw", 2'd1, 6'h23, 6'h00, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1,
            1'b1, 10'h001, 32'h8FA80004, 1'b0, w);
    waitDone("lw");
    check("lw_count", word_count, 2);

    // J-format with req_valid held: ready drops for exactly the write cycle
    doStart(10'h100);
    sendReq("j", 2'd2, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b0,
            1'b1, 10'h100, 32'h08100000, 1'b1, w);
    check("j_ready_low_in_write", req_ready, 0);
    sendReq("jal", 2'd2, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1'b1,
            1'b1, 10'h101, 32'h0C000040, 1'b0, w);
    check("jal_wait_cycles", w, 1);
    waitDone("jal");
    check("jal_count", word_count, 2);

    // Overflow at the top of memory: third request must never be accepted
    doStart(10'h3FE);
    sendReq("ovf0", 2'd1, 6'h09, 6'h00, 5'd1, 5'd2, 5'd0, 16'h1111, 26'h0, 1'b0,
            1'b1, 10'h3FE, 32'h24221111, 1'b1, w);
    sendReq("ovf1", 2'd1, 6'h09, 6'h00, 5'd1, 5'd2, 5'd0, 16'h2222, 26'h0, 1'b0,
            1'b1, 10'h3FF, 32'h24222222, 1'b1, w);
    req_imm = 16'h3333;
    @(posedge clk); #1;
    check("ovf_flag", err_ovf, 1);
    check("ovf_done", done, 1);
    check("ovf_ready_in_done", req_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_idle", busy, 0);
    check("ovf_ready_idle", req_ready, 0);
    check("ovf_count", word_count, 2);
    check("ovf_sticky", err_ovf, 1);
    req_valid = 1'b0;

    // Unsupported R func 0x3F; new start also clears the overflow flag
    doStart(10'h200);
    check("ovf_cleared", err_ovf, 0);
`ifdef ENC_OPCHECK_EN
    sendReq("badfn", 2'd0, 6'h00, 6'h3F, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0,
            1'b0, 10'h000, 32'h0, 1'b0, w);
    check("badfn_invop", err_invop, 1);
    check("badfn_still_accept", req_ready, 1);
    check("badfn_count", word_count, 0);
    @(posedge clk); #1;
    check("badfn_invop_pulse_end", err_invop, 0);
    sendReq("sub", 2'd0, 6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1,
            1'b1, 10'h200, 32'h00853022, 1'b0, w);
    waitDone("sub");
    check("sub_count", word_count, 1);
    // Invalid last request ends the session with nothing written
    doStart(10'h300);
    sendReq("rsvd_last", 2'd3, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1,
            1'b0, 10'h000, 32'h0, 1'b0, w);
    check("rsvd_invop", err_invop, 1);
    waitDone("rsvd");
    check("rsvd_count", word_count, 0);
`else
    sendReq("badfn", 2'd0, 6'h00, 6'h3F, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0,
            1'b1, 10'h200, 32'h0000003F, 1'b0, w);
    check("badfn_invop_tied", err_invop, 0);
    @(posedge clk); #1;
    check("badfn_count", word_count, 1);
    sendReq("sub", 2'd0, 6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1,
            1'b1, 10'h201, 32'h00853022, 1'b0, w);
    waitDone("sub");
    check("sub_count", word_count, 2);
`endif

    // Back-to-back ORI words with random fields
    doStart(10'h080);
    for (int i = 0; i < 6; i++) begin
      logic [4:0]  rt;
      logic [15:0] imm;
      rt  = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      sendReq("ori", 2'd1, 6'h0D, 6'h00, 5'd7, rt, 5'd0, imm, 26'h0, i == 5,
              1'b1, 10'h080 + 10'(i), {6'h0D, 5'd7, rt, imm}, 1'b0, w);
    end
    waitDone("ori");
    check("ori_count", word_count, 6);

    // Reset in the middle of a write cycle
    doStart(10'h050);
    req_fmt = 2'd1; req_op = 6'h08; req_rs = 5'd1; req_rt = 5'd2; req_imm = 16'h00AA;
    req_last = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("prerst_we", imem_we, 1);
    rst = 1'b1;
    #1;
    check("rst_async_we", imem_we, 0);
    check("rst_async_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_busy", busy, 0);
    check("postrst_count", word_count, 0);
    check("postrst_done", done, 0);

    check("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
